ppm_encoder: RTL

1-of-4 pulse-position-modulation transmitter clocked by the 16x oversampling clock. It serialises a byte stream into SOF, data symbols and EOF on an active-low `Dout` line. It is the transmit-side counterpart of the PPM decoder chain, so the receive path can be driven by it in loopback. A single-entry holding register with valid/ready handshake supports back-to-back bytes without inter-symbol gaps.

---
 rtl/ppm_encoder.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ppm_encoder.sv
// ppm_encoder: 1-of-4 PPM transmitter that sends SOF, 2-bit data symbols and EOF on an active-low Dout.
// Optional feature macro PPM_ENC_XSUM_EN appends an XOR checksum byte before EOF.
module ppm_encoder #(
  parameter int SLOT_CLKS  = 16,
  parameter int PULSE_CLKS = 4
) (
  input  logic       clk16,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       Dout,
  output logic       busy,
  output logic       frame_done,
  output logic       tx_err
);
  localparam int CW = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CLKS - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CLKS - 1);

  typedef enum logic [2:0] {IDLE, SOF, DATA, XSUM, EOF} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    slot_q, slot_d;
  logic [1:0]    sym_q, sym_d;
  logic [7:0]    shift_q, shift_d;
  logic          cur_last_q, cur_last_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_valid_q, hold_valid_d;
  logic          hold_last_q, hold_last_d;
  logic          last_seen_q, last_seen_d;
  logic          dout_q, dout_d;
  logic          frame_done_q, frame_done_d;
  logic          tx_err_q, tx_err_d;
`ifdef PPM_ENC_XSUM_EN
  logic [7:0]    xor_q, xor_d;
`endif

  logic slot_end, byte_end, accept, pulse_slot;

  // Handshake: a byte transfers on the rising edge where tx_valid && tx_ready; tx_ready
  // depends only on registered state, and tx_data/tx_last must be stable while tx_valid is high.
  assign tx_ready   = (state_q == IDLE) || (!hold_valid_q && !last_seen_q);
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state_q != IDLE);
  assign Dout       = dout_q;
  assign frame_done = frame_done_q;
  assign tx_err     = tx_err_q;
  assign slot_end   = (cyc_q == SLOT_LAST);

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    sym_d        = sym_q;
    shift_d      = shift_q;
    cur_last_d   = cur_last_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    hold_last_d  = hold_last_q;
    last_seen_d  = last_seen_q;
    frame_done_d = 1'b0;
    tx_err_d     = 1'b0;
    byte_end     = 1'b0;
    pulse_slot   = 1'b0;
`ifdef PPM_ENC_XSUM_EN
    xor_d        = xor_q;
`endif
    cyc_d = (state_q == IDLE || slot_end) ? '0 : cyc_q + CW'(1);

    case (state_q)
      IDLE: begin
        slot_d      = '0;
        sym_d       = '0;
        last_seen_d = 1'b0;
`ifdef PPM_ENC_XSUM_EN
        xor_d       = '0;
`endif
        // A byte parked in the hold register after an underrun opens the next frame.
        if (hold_valid_q) begin
          state_d      = SOF;
          shift_d      = hold_q;
          cur_last_d   = hold_last_q;
          last_seen_d  = hold_last_q;
          hold_valid_d = 1'b0;
`ifdef PPM_ENC_XSUM_EN
          xor_d        = hold_q;
`endif
          if (accept) begin
            hold_d       = tx_data;
            hold_last_d  = tx_last;
            hold_valid_d = 1'b1;
            last_seen_d  = hold_last_q | tx_last;
          end
        end else if (accept) begin
          state_d     = SOF;
          shift_d     = tx_data;
          cur_last_d  = tx_last;
          last_seen_d = tx_last;
`ifdef PPM_ENC_XSUM_EN
          xor_d       = tx_data;
`endif
        end
      end
      SOF: begin
        if (slot_end) begin
          if (slot_q == 3'd7) begin
            state_d = DATA;
            slot_d  = '0;
            sym_d   = '0;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      end
      DATA, XSUM: begin
        if (slot_end) begin
          if (slot_q == 3'd3) begin
            slot_d   = '0;
            sym_d    = sym_q + 2'd1;
            shift_d  = {2'b00, shift_q[7:2]};
            byte_end = (sym_q == 2'd3);
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      end
      EOF: begin
        if (slot_end) begin
          if (slot_q == 3'd3) begin
            state_d      = IDLE;
            slot_d       = '0;
            frame_done_d = 1'b1;
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (byte_end) begin
      if (state_q != DATA) begin
        state_d = EOF;
      end else if (!cur_last_q && hold_valid_q) begin
        shift_d      = hold_q;
        cur_last_d   = hold_last_q;
        hold_valid_d = 1'b0;
`ifdef PPM_ENC_XSUM_EN
        xor_d        = xor_q ^ hold_q;
`endif
      end else begin
        tx_err_d = !cur_last_q;
`ifdef PPM_ENC_XSUM_EN
        state_d  = XSUM;
        shift_d  = xor_q;
`else
        state_d  = EOF;
`endif
      end
    end

    if (state_q != IDLE && accept) begin
      hold_d       = tx_data;
      hold_last_d  = tx_last;
      hold_valid_d = 1'b1;
      if (tx_last) last_seen_d = 1'b1;
    end

    // Dout is computed from the next-cycle view so the registered line lines up with the state.
    case (state_d)
      SOF:       pulse_slot = (slot_d == 3'd1) || (slot_d == 3'd7);
      DATA, XSUM: pulse_slot = (slot_d[1:0] == shift_d[1:0]);
      EOF:       pulse_slot = (slot_d == 3'd0) || (slot_d == 3'd2);
      default:   pulse_slot = 1'b0;
    endcase
    dout_d = !(pulse_slot && (cyc_d <= PULSE_LAST));
  end

  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      slot_q       <= '0;
      sym_q        <= '0;
      shift_q      <= '0;
      cur_last_q   <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_last_q  <= 1'b0;
      last_seen_q  <= 1'b0;
      dout_q       <= 1'b1;
      frame_done_q <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      slot_q       <= slot_d;
      sym_q        <= sym_d;
      shift_q      <= shift_d;
      cur_last_q   <= cur_last_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      hold_last_q  <= hold_last_d;
      last_seen_q  <= last_seen_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
      tx_err_q     <= tx_err_d;
    end
  end

`ifdef PPM_ENC_XSUM_EN
  always_ff @(posedge clk16 or posedge rst) begin
    if (rst) xor_q <= '0;
    else     xor_q <= xor_d;
  end
`endif

endmodule
